mem_lsu_align: RTL and testbench

Load/store alignment front-end that sits directly upstream of the 256×32 byte-masked data memory. It accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake. It converts each request into one word-addressed memory access with the correct write byte mask and lane-replicated write data. For loads it extracts the addressed lanes from the memory's registered read data, sign- or zero-extends them, and returns the result over a valid/ready response channel.

---
 rtl/mem_lsu_align_if.sv | 41 ++++
 rtl/mem_lsu_align.sv | 145 ++++++++++++++
 tb/tb_mem_lsu_align.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_align_if.sv
// Request/response/memory bundle for mem_lsu_align. The slave modport is the
// alignment block; the master modport is the side that issues requests and owns the memory.
interface mem_lsu_align_if #(
    parameter int ADDR_W = 10
) ();
    // Both channels transfer on a rising clk edge where valid && ready.
    // Once raised, valid and its payload stay stable until that edge.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-3:0] mem_addr;
    logic              mem_wr;
    logic              mem_c_en;
    logic [3:0]        mem_w_mask;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wr, mem_c_en, mem_w_mask, mem_wr_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wr, mem_c_en, mem_w_mask, mem_wr_data
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-addressed load/store alignment in front of a 256x32 byte-masked memory.
// Optional MEM_LSU_MISALIGN_TRAP_EN rejects misaligned and reserved-size requests.
module mem_lsu_align #(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_lsu_align_if.slave        bus,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

    state_t            state, state_nxt;
    logic              accept, rsp_hs, reject;
    logic              we_q, uns_q;
    logic [1:0]        size_q, lane_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-3:0] addr_q;
    logic              c_en_q, wr_q;
    logic [3:0]        mask_q, mask_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic [4:0]        shamt;
    logic [31:0]       shifted, load_ext;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign rsp_hs        = (state == RESP) && bus.rsp_ready;

    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_c_en    = c_en_q;
    assign bus.mem_wr      = wr_q;
    assign bus.mem_w_mask  = mask_q;
    assign bus.mem_wr_data = wdata_q;
    assign state_dbg       = state;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic err_q;

    assign reject = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst)         err_q <= 1'b0;
        else if (accept) err_q <= reject;
        else if (rsp_hs) err_q <= 1'b0;
    end

    assign bus.rsp_err = err_q;
`else
    assign reject      = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = reject ? RESP : ACCESS;
            ACCESS:  state_nxt = we_q ? RESP : DATA;
            DATA:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane mask and replicated store data, computed from the live request.
    always_comb begin
        mask_nxt  = 4'b0000;
        wdata_nxt = 32'h0;
        case (bus.req_size)
            2'b00: begin
                mask_nxt  = 4'b0001 << bus.req_addr[1:0];
                wdata_nxt = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                mask_nxt  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                mask_nxt  = 4'b1111;
                wdata_nxt = bus.req_wdata;
            end
        endcase
    end

    // Halves ignore addr[0] and words ignore addr[1:0] when misaligned requests are allowed.
    always_comb begin
        shamt = 5'd0;
        case (size_q)
            2'b00:   shamt = {lane_q, 3'b000};
            2'b01:   shamt = {lane_q[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        shifted  = bus.mem_rd_data >> shamt;
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            rdata_q <= 32'h0;
            addr_q  <= '0;
            c_en_q  <= 1'b0;
            wr_q    <= 1'b0;
            mask_q  <= 4'b0000;
            wdata_q <= 32'h0;
        end else begin
            c_en_q  <= 1'b0;
            wr_q    <= 1'b0;
            mask_q  <= 4'b0000;
            wdata_q <= 32'h0;
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                lane_q  <= bus.req_addr[1:0];
                rdata_q <= 32'h0;
                if (!reject) begin
                    addr_q  <= bus.req_addr[ADDR_W-1:2];
                    c_en_q  <= 1'b1;
                    wr_q    <= bus.req_we;
                    mask_q  <= mask_nxt;
                    wdata_q <= wdata_nxt;
                end
            end
            if (state == DATA) rdata_q <= load_ext;
            if (rsp_hs)        rdata_q <= 32'h0;
        end
    end
endmodule

// File: tb/tb_mem_lsu_align.sv
// Directed plus random bench for mem_lsu_align with a behavioural 256x32
// byte-masked memory, a reference memory image and an expected-response queue.
module tb_mem_lsu_align;
    localparam int ADDR_W = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_init;
    logic [1:0] state_dbg;

    mem_lsu_align_if #(.ADDR_W(ADDR_W)) bus ();

    mem_lsu_align #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    logic [32:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    // Memory: masked write on c_en&wr, registered read on c_en&!wr.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
            bus.mem_rd_data <= 32'h0;
        end else if (bus.mem_c_en) begin
            if (bus.mem_wr) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_w_mask[b]) mem_arr[bus.mem_addr][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
            end else begin
                bus.mem_rd_data <= mem_arr[bus.mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_rej(input logic [1:0] size, input logic [9:0] addr);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] size, input logic [9:0] addr);
        if (size == 2'd0) begin
            case (addr[1:0])
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (size == 2'd1) return addr[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (size == 2'd1) return {w[15:0], w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns, input logic [9:0] addr);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = ref_mem[addr[9:2]];
        b = w[8*addr[1:0] +: 8];
        h = addr[1] ? w[31:16] : w[15:0];
        if (size == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
        if (size == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    // Issue one request at a negedge, follow it to the response handshake.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wdata, input int hold);
        bit          rej;
        logic [31:0] exp_rd;
        logic [32:0] e;
        logic [3:0]  m;
        logic [31:0] d;
        int          lat, exp_lat, cen_cnt;
        rej     = is_rej(size, addr);
        exp_rd  = (we || rej) ? 32'h0 : exp_load(size, uns, addr);
        exp_lat = rej ? 1 : (we ? 2 : 3);
        exp_q.push_back({rej, exp_rd});
        if (we && !rej) begin
            m = exp_mask(size, addr);
            d = exp_wdata(size, wdata);
            for (int b = 0; b < 4; b++) if (m[b]) ref_mem[addr[9:2]][8*b +: 8] = d[8*b +: 8];
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        check("req_ready_idle", bus.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        cen_cnt = 0;
        while (!bus.rsp_valid && lat < 20) begin
            if (bus.mem_c_en) cen_cnt++;
            if (lat == 1) begin
                check("access_c_en", bus.mem_c_en, 1);
                check("access_wr", bus.mem_wr, we);
                check("access_addr", bus.mem_addr, addr[9:2]);
                if (we) begin
                    check("access_mask", bus.mem_w_mask, exp_mask(size, addr));
                    check("access_wdata", bus.mem_wr_data, exp_wdata(size, wdata));
                end
            end
            check("req_ready_busy", bus.req_ready, 0);
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_seen", bus.rsp_valid, 1);
        check("latency", lat, exp_lat);
        check("c_en_pulses", cen_cnt, rej ? 0 : 1);
        check("resp_c_en_idle", {bus.mem_c_en, bus.mem_wr, bus.mem_w_mask}, 0);
        check("resp_wdata_idle", bus.mem_wr_data, 0);
        e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e[31:0]);
        check("rsp_err", bus.rsp_err, e[32]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_rdata", bus.rsp_rdata, e[31:0]);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        mem_init         = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_mem_ctl", {bus.mem_c_en, bus.mem_wr, bus.mem_w_mask}, 0);
        check("rst_mem_wdata", bus.mem_wr_data, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_state", state_dbg, 0);
        rst      = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        check("first_req_ready", bus.req_ready, 1);

        do_req(1'b1, 2'd2, 1'b0, 10'h000, 32'h11223344, 0);
        do_req(1'b1, 2'd2, 1'b0, 10'h00C, 32'h80FF1234, 0);
        do_req(1'b0, 2'd1, 1'b0, 10'h00E, 32'h0, 0);
        check("ref_half_signed", exp_load(2'd1, 1'b0, 10'h00E), 32'hFFFF80FF);
        do_req(1'b0, 2'd1, 1'b1, 10'h00E, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b1, 10'h001, 32'h0, 0);
        do_req(1'b0, 2'd2, 1'b0, 10'h002, 32'h0, 0);
        do_req(1'b0, 2'd3, 1'b0, 10'h000, 32'h0, 1);
        do_req(1'b0, 2'd0, 1'b0, 10'h00F, 32'h0, 0);
        do_req(1'b1, 2'd0, 1'b0, 10'h00D, 32'h000000A5, 0);
        do_req(1'b0, 2'd2, 1'b0, 10'h00C, 32'h0, 5);
        check("ref_after_byte_store", ref_mem[3], 32'h80FFA534);
        do_req(1'b1, 2'd2, 1'b0, 10'h000, 32'hDEADBEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0, 0);
        do_req(1'b1, 2'd1, 1'b0, 10'h012, 32'h0000C3D4, 0);
        do_req(1'b0, 2'd1, 1'b0, 10'h012, 32'h0, 0);

        for (int i = 0; i < 14; i++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   10'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));

        // Reset while the load sits in DATA: the response must be dropped.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 10'h000;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_state_data", state_dbg, 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_req_ready", bus.req_ready, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
        check("mid_rst_rsp_err", bus.rsp_err, 0);
        check("mid_rst_mem_ctl", {bus.mem_c_en, bus.mem_wr, bus.mem_w_mask}, 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        check("mid_rst_state", state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_req_ready_after", bus.req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", bus.rsp_valid, 0);
        end
        do_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b0, 10'h003, 32'h0, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
